// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data-memory responder
package dmem_pkg;
  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'h0000_FFFC;
  typedef struct packed {
    logic [29:0] index;
    logic [31:0] data;
  } sb_entry_t;
  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction
endpackage

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order circular store FIFO with youngest-match lookup
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PW = $clog2(SB_DEPTH),
  localparam int CW = $clog2(SB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  sb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic [29:0]       lookup_idx_i,
  output sb_entry_t         head_o,
  output logic [CW-1:0]     count_o,
  output logic              hit_o,
  output logic [31:0]       hit_data_o
);
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  sb_entry_t     mem_q [SB_DEPTH];
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  // pointer and occupancy update; push and pop are never requested together
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i) head_q <= head_q + 1'b1;
      count_q <= push_i ? count_q + 1'b1 : pop_i ? count_q - 1'b1 : count_q;
    end
  end
  // entry storage, payload needs no reset
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[tail_q] <= push_entry_i;
  end
  // scan oldest to youngest so the last match seen is the youngest store
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (CW'(k) < count_q && mem_q[head_q + PW'(k)].index == lookup_idx_i) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[head_q + PW'(k)].data;
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: store-buffered word RAM with forwarding; optional completion register under DMEM_MMIO_EN
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          SB_DEPTH    = 4,
  parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEFAULT,
  localparam int         CW          = $clog2(SB_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          stall,
  output logic [CW-1:0] sb_count,
  output logic          mmio_done,
  output logic [31:0]   mmio_value
);
  localparam int IW = idx_w(DEPTH_WORDS);
`ifdef DMEM_MMIO_EN
  localparam logic MMIO_EN = 1'b1;
`else
  localparam logic MMIO_EN = 1'b0;
`endif
  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [IW-1:0] idx;
  logic          is_mmio, mmio_wr, push, drain, hit;
  logic [31:0]   hit_data;
  sb_entry_t     head;
  logic          mmio_done_q;
  logic [31:0]   mmio_value_q;
  assign idx        = dataadr[IW+1:2];
  assign is_mmio    = MMIO_EN && dataadr == MMIO_ADDR;
  assign mmio_wr    = memwrite && is_mmio;
  assign stall      = sb_count == CW'(SB_DEPTH);
  assign push       = memwrite && !is_mmio && !stall;
  assign drain      = !reset && sb_count != '0 && !push && !mmio_wr;
  assign mmio_done  = mmio_done_q;
  assign mmio_value = mmio_value_q;
  dmem_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i ('{index: 30'(idx), data: writedata}),
    .pop_i        (drain),
    .lookup_idx_i (30'(idx)),
    .head_o       (head),
    .count_o      (sb_count),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );
  // retire the head entry into RAM on cycles with no accepted store
  always_ff @(posedge clk) begin
    if (drain) ram_q[IW'(head.index)] <= head.data;
  end
  // completion register, sticky until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_done_q  <= 1'b0;
      mmio_value_q <= '0;
    end else if (mmio_wr) begin
      mmio_done_q  <= 1'b1;
      mmio_value_q <= writedata;
    end
  end
  // load path: completion register, then youngest buffered store, then RAM
  always_comb begin
    readdata = is_mmio ? mmio_value_q : hit ? hit_data : ram_q[idx];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized scoreboard bench against a queue-based memory model
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int SB = 4;
  localparam logic [31:0] MADDR = 32'h0000_FFFC;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        stall;
  logic [2:0]  sb_count;
  logic        mmio_done;
  logic [31:0] mmio_value;
  dmem_responder #(.DEPTH_WORDS(DEPTH), .SB_DEPTH(SB), .MMIO_ADDR(MADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .sb_count   (sb_count),
    .mmio_done  (mmio_done),
    .mmio_value (mmio_value)
  );
  always #5 clk = ~clk;
  typedef struct {
    int          idx;
    logic [31:0] d;
  } st_t;
  typedef struct {
    bit          rd_known;
    logic [31:0] rd;
    logic        stall;
    logic [2:0]  cnt;
    logic        done;
    logic [31:0] val;
  } exp_t;
  st_t         pend[$];
  logic [31:0] ram [DEPTH];
  bit          known [DEPTH];
  bit          m_done;
  logic [31:0] m_val;
  bit          model_valid = 1'b0;
  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  function automatic exp_t expect_now(input logic [31:0] a);
    exp_t e;
    int   ix;
    ix = int'((a >> 2) % DEPTH);
    e.rd_known = 1'b0;
    e.rd = '0;
    if (MMIO && a == MADDR) begin
      e.rd_known = 1'b1;
      e.rd = m_val;
    end else begin
      for (int i = 0; i < pend.size(); i++)
        if (pend[i].idx == ix) begin
          e.rd_known = 1'b1;
          e.rd = pend[i].d;
        end
      if (!e.rd_known && known[ix]) begin
        e.rd_known = 1'b1;
        e.rd = ram[ix];
      end
    end
    e.stall = pend.size() == SB;
    e.cnt = 3'(pend.size());
    e.done = m_done;
    e.val = m_val;
    return e;
  endfunction
  task automatic model_edge(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    st_t s;
    if (r) begin
      pend.delete();
      m_done = 1'b0;
      m_val = '0;
      model_valid = 1'b1;
    end else if (MMIO && w && a == MADDR) begin
      m_done = 1'b1;
      m_val = d;
    end else if (w && pend.size() < SB) begin
      s.idx = int'((a >> 2) % DEPTH);
      s.d = d;
      pend.push_back(s);
    end else if (pend.size() > 0) begin
      s = pend.pop_front();
      ram[s.idx] = s.d;
      known[s.idx] = 1'b1;
    end
  endtask
  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    reset = r;
    memwrite = w;
    dataadr = a;
    writedata = d;
    if (model_valid) expq.push_back(expect_now(a));
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("sb_count", 32'(sb_count), 32'(e.cnt));
      chk("mmio_done", 32'(mmio_done), 32'(e.done));
      chk("mmio_value", mmio_value, e.val);
      if (e.rd_known) chk("readdata", readdata, e.rd);
    end
  end
  initial begin
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    m_done = 1'b0;
    m_val = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 32'h54, 32'd7);
    step(0, 0, 32'h54, 0);
    step(0, 0, 32'h54, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 32'(i * 4), $urandom);
      step(0, 0, 32'(i * 4), 0);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) step(0, 1, 32'h10, 32'h104);
    for (int i = 0; i < 6; i++) step(0, 0, 32'(i % 5 * 4), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 32'(i * 4), 0);
    step(0, 1, 32'h20, 32'd10);
    step(0, 1, 32'h20, 32'd20);
    step(0, 0, 32'h20, 0);
    step(0, 0, 32'h20, 0);
    step(0, 0, 32'h20, 0);
    step(0, 1, 32'h100, 32'hAA);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    step(0, 1, 32'hC, 32'd5);
    step(0, 0, 32'hC, 0);
    step(0, 1, 32'hC, 32'd9);
    step(1, 0, 32'hC, 0);
    step(0, 0, 32'hC, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h40 + 32'(i * 4), $urandom);
    step(0, 1, MADDR, 32'h7);
    step(0, 0, MADDR, 0);
    for (int i = 0; i < 1500; i++) begin
      a = {22'($urandom_range(0, 3)), 10'($urandom_range(0, 15) * 4 + $urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) a = MADDR;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, a, $urandom);
    end
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_queue: %0d left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
